// File: rtl/cnn_window_stream.sv
// Sliding-window generator: buffers KY-1 image lines of a raster pixel stream and
// emits one KX x KY x CI window per output position, with valid/ready on both sides.
module cnn_window_stream #(
  parameter int I_F_BW = 8,
  parameter int CI     = 1,
  parameter int KX     = 5,
  parameter int KY     = 5,
  parameter int IX     = 28,
  parameter int IY     = 28,
  parameter int STRIDE = 1,
  localparam int PW    = CI * I_F_BW,
  localparam int OX    = (IX - KX) / STRIDE + 1,
  localparam int OY    = (IY - KY) / STRIDE + 1,
  localparam int CW    = $clog2((IX > IY) ? IX : IY)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_valid,
  output logic                   o_in_ready,
  input  logic [PW-1:0]          i_pixel,
  output logic                   o_win_valid,
  input  logic                   i_win_ready,
  output logic [KX*KY*PW-1:0]    o_window,
  output logic [CW-1:0]          o_ox,
  output logic [CW-1:0]          o_oy,
  output logic                   o_done
);

  localparam logic [CW-1:0] COL_LAST  = CW'(IX - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(IY - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KX - 1);
  localparam logic [CW-1:0] ROW_FIRST = CW'(KY - 1);
  localparam logic [CW-1:0] OX_LAST   = CW'(OX - 1);
  localparam logic [CW-1:0] OY_LAST   = CW'(OY - 1);

  logic [CW-1:0]       col_q, col_d, row_q, row_d;
  logic [CW-1:0]       ox_q, ox_d, oy_q, oy_d;
  logic [KX*KY*PW-1:0] win_q, win_d;
  logic                win_valid_q, win_valid_d;
  logic                done_q, done_d;
  logic [PW-1:0]       line_buf_q [KY-1][IX];
  logic                accept, qualify;
  logic [CW-1:0]       col_off, row_off;

  assign o_in_ready = reset_n && (!win_valid_q || i_win_ready);
  assign accept     = i_valid && o_in_ready;
  assign col_off    = col_q - COL_FIRST;
  assign row_off    = row_q - ROW_FIRST;
  // With stride 2 only even offsets from the first full window position produce output.
  assign qualify    = (col_q >= COL_FIRST) && (row_q >= ROW_FIRST) &&
                      ((STRIDE == 1) || (!col_off[0] && !row_off[0]));

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    done_d      = win_valid_q && i_win_ready && (ox_q == OX_LAST) && (oy_q == OY_LAST);
    if (win_valid_q && i_win_ready) win_valid_d = 1'b0;
    if (accept) begin
      col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
      if (col_q == COL_LAST) row_d = (row_q == ROW_LAST) ? '0 : row_q + CW'(1);
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX - 1; kx++) begin
          win_d[(ky*KX + kx)*PW +: PW] = win_q[(ky*KX + kx + 1)*PW +: PW];
        end
      end
      // Rightmost column: oldest buffered line on top, the incoming pixel at the bottom.
      for (int ky = 0; ky < KY - 1; ky++) begin
        win_d[(ky*KX + KX - 1)*PW +: PW] = line_buf_q[KY-2-ky][col_q];
      end
      win_d[((KY-1)*KX + KX - 1)*PW +: PW] = i_pixel;
      win_valid_d = qualify;
      if (qualify) begin
        ox_d = (STRIDE == 2) ? (col_off >> 1) : col_off;
        oy_d = (STRIDE == 2) ? (row_off >> 1) : row_off;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      ox_q        <= '0;
      oy_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      done_q      <= done_d;
    end
  end

  // NOTE: the line buffers are plain storage with no reset so they can map onto RAM;
  // stale contents never reach a valid window because of the row/col qualification.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf_q[0][col_q] <= i_pixel;
      for (int k = 0; k < KY - 2; k++) begin
        line_buf_q[k+1][col_q] <= line_buf_q[k][col_q];
      end
    end
  end

  assign o_win_valid = win_valid_q;
  assign o_window    = win_q;
  assign o_ox        = ox_q;
  assign o_oy        = oy_q;
  assign o_done      = done_q;

endmodule

// File: doc/cnn_window_stream.md
# cnn_window_stream

Parametrised sliding-window generator for the CNN datapath: accepts a raster-order pixel stream with a valid/ready handshake, buffers KY-1 image lines, and emits one KX×KY×CI window per output position with its output coordinates. It is the next-generation front end of the convolution stage. Relative to the fixed 5×5, single-channel, always-accepting line buffer, it adds multi-channel pixels, configurable stride, downstream backpressure, and a frame-done pulse. It feeds the MAC array directly.

## Interface
- I_F_BW, 8, bits per channel sample
- CI, 1, channels packed per pixel
- KX, 5, kernel width
- KY, 5, kernel height
- IX, 28, image width in pixels
- IY, 28, image height in pixels
- STRIDE, 1, window step in x and y; legal values 1 or 2
- Derived: PW=CI*I_F_BW; OX=(IX-KX)/STRIDE+1; OY=(IY-KY)/STRIDE+1; CW=$clog2(max(IX,IY))
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- i_valid  in  1  input pixel valid
- o_in_ready  out  1  block can accept a pixel this cycle
- i_pixel  in  PW  pixel; channel c at [c*I_F_BW +: I_F_BW]
- o_win_valid  out  1  window valid
- i_win_ready  in  1  downstream accepts the window
- o_window  out  KX*KY*PW  window; element (ky,kx) at [(ky*KX+kx)*PW +: PW]; ky=0 is the top (oldest) row, kx=0 is the leftmost column
- o_ox, o_oy  out  CW each  output coordinates of the window
- o_done  out  1  one-cycle pulse when the final window of a frame is accepted downstream

## Operation
- Input accept: i_valid && o_in_ready. o_in_ready = reset_n && (!o_win_valid || i_win_ready).
- Counters col (0..IX-1) and row (0..IY-1) advance on each accept.
  - col wraps to 0 at IX-1 and row increments.
  - At row=IY-1, col=IX-1, both wrap to 0.
- Line buffers: KY-1 buffers of IX×PW. On accept at col, buffer k+1 takes the old buffer k[col], and buffer 0 takes i_pixel.
- Window register: a KX-deep column shift. On accept, each column shifts left by one. The new rightmost column is {line_buf[KY-2][col] (top) … line_buf[0][col], i_pixel (bottom)}.
- Qualifying accept: row≥KY-1 && col≥KX-1 && (row-KY+1)%STRIDE==0 && (col-KX+1)%STRIDE==0.
- On a qualifying accept, in the next cycle:
  - o_win_valid=1
  - o_window = the shifted window
  - o_ox = (col-KX+1)/STRIDE
  - o_oy = (row-KY+1)/STRIDE
- Window columns left over from the previous line are never emitted, because the col≥KX-1 gate excludes them. Line buffers are not cleared between frames.
- o_done: asserted for exactly one cycle after o_win_valid && i_win_ready with o_ox=OX-1 and o_oy=OY-1.
- Trailing pixels that produce no window (stride remainder) are still accepted and counted.

## Timing
- Reset (reset_n=0 at a clk edge) sets the following on that edge:
  - col=0, row=0
  - o_win_valid=0, o_done=0
  - o_window=0, o_ox=0, o_oy=0
- o_in_ready=0 while reset_n is low. Line-buffer contents are don't-care after reset.
- Latency: a qualifying accept at edge N makes o_win_valid high after edge N, with a full window available.
- Backpressure: while o_win_valid && !i_win_ready, o_in_ready=0. o_window, o_ox, o_oy, the counters, and the line buffers all hold.
- Simultaneous window handoff and new accept in one cycle: the window is consumed and the new pixel is accepted. o_win_valid stays 1 if the new pixel qualifies, otherwise it drops to 0. Full throughput is one pixel per cycle.
- A non-qualifying accept or an idle cycle with the window consumed sets o_win_valid=0.
- Back-to-back frames: the first pixel of frame n+1 may be accepted on the cycle after the last pixel of frame n. o_done for frame n is not delayed by frame n+1.
- Reset mid-frame: state is discarded. The next accepted pixel is treated as (row 0, col 0).

## Test plan
- 28×28 ramp (pixel = 28r+c+1), K=5, STRIDE=1, CI=1, i_win_ready=1:
  - window (0,0) = {1..5, 29..33, 57..61, 85..89, 113..117}, sum 1475
  - exactly 576 windows
  - last window (23,23) has top-left 668
  - o_done pulses once, on the cycle after window (23,23) is accepted
- Same frame with STRIDE=2: 144 windows; window (1,0) top-left=3; window (11,11) top-left 28*22+22+1=639; one o_done.
- Backpressure: hold i_win_ready=0 for 10 cycles at window (0,0):
  - o_window stable and o_in_ready=0 throughout
  - all 576 windows match the no-stall run
  - no pixel lost or duplicated
- Random i_valid gaps plus random i_win_ready: output sequence is identical to the unstalled run.
- Reset after 300 accepted pixels, then send a full frame: first window (0,0) has sum 1475; 576 windows; one o_done.
- CI=3, channel c = ramp+c*1000 (mod 256 per channel), two back-to-back frames: every channel slice matches the per-channel model; two o_done pulses, 576 windows each.
